// File: rtl/bsg_counter_underflow_pkg.sv
// Shared types and constants for the underflow/reload down-counter.
package bsg_counter_underflow_pkg;

  typedef enum logic {
    e_idle = 1'b0,
    e_run  = 1'b1
  } state_e;

  localparam int event_cnt_width_gp = 8;

endpackage

// File: rtl/bsg_counter_underflow_reload_en_if.sv
// Load/control/status bundle for bsg_counter_underflow_reload_en.
// Optional macro BSG_COUNTER_UNDERFLOW_EVENT_CNT_EN adds underflow_cnt_o.
interface bsg_counter_underflow_reload_en_if #(
  parameter int width_p = 31
);
  import bsg_counter_underflow_pkg::*;

  logic               v_i;
  logic [width_p-1:0] val_i;
  logic               periodic_i;
  logic               ready_o;
  logic               set_i;
  logic               en_i;
  logic               abort_i;
  logic [width_p-1:0] count_o;
  logic               busy_o;
  logic               underflow_o;
`ifdef BSG_COUNTER_UNDERFLOW_EVENT_CNT_EN
  logic [event_cnt_width_gp-1:0] underflow_cnt_o;

  modport master (
    output v_i, val_i, periodic_i, set_i, en_i, abort_i,
    input  ready_o, count_o, busy_o, underflow_o, underflow_cnt_o
  );

  modport slave (
    input  v_i, val_i, periodic_i, set_i, en_i, abort_i,
    output ready_o, count_o, busy_o, underflow_o, underflow_cnt_o
  );
`else
  modport master (
    output v_i, val_i, periodic_i, set_i, en_i, abort_i,
    input  ready_o, count_o, busy_o, underflow_o
  );

  modport slave (
    input  v_i, val_i, periodic_i, set_i, en_i, abort_i,
    output ready_o, count_o, busy_o, underflow_o
  );
`endif

endinterface

// File: rtl/bsg_counter_down_set_en.sv
// Down-counter datapath: set has priority over decrement, holds at zero.
module bsg_counter_down_set_en #(
  parameter int width_p = 31
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               set_i,
  input  logic [width_p-1:0] val_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o,
  output logic               zero_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (set_i) begin
      r_count <= val_i;
    end else if (en_i && (r_count != '0)) begin
      r_count <= r_count - width_p'(1);
    end
  end

  assign count_o = r_count;
  assign zero_o  = (r_count == '0);

endmodule

// File: rtl/bsg_counter_underflow_reload_en.sv
// Loadable down-counter/timer with one-shot or periodic reload on underflow.
// Optional macro BSG_COUNTER_UNDERFLOW_EVENT_CNT_EN adds a saturating underflow event count.
module bsg_counter_underflow_reload_en
  import bsg_counter_underflow_pkg::*;
#(
  parameter int max_val_p        = 2147483647,
  parameter int reload_default_p = 0
) (
  input logic clk_i,
  input logic reset_i,
  bsg_counter_underflow_reload_en_if.slave bus_if
);

  localparam int width_lp = $clog2(64'(max_val_p) + 64'd1);
  localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);

  function automatic logic [width_lp-1:0] clamp(input logic [width_lp-1:0] v);
    return (v > max_lp) ? max_lp : v;
  endfunction

  state_e              r_state;
  logic [width_lp-1:0] r_reload;
  logic                r_mode;
  logic                r_underflow;

  logic                w_idle;
  logic                w_accept;
  logic                w_abort;
  logic                w_set;
  logic                w_en;
  logic                w_zero;
  logic                w_uf;
  logic                w_cnt_set;
  logic [width_lp-1:0] w_cnt_val;
  logic [width_lp-1:0] w_count;
  logic [width_lp-1:0] w_clamped;

  assign w_idle    = (r_state == e_idle);
  assign w_clamped = clamp(bus_if.val_i);

  // RUN priority chain: abort > set > decrement/underflow.
  assign w_accept  = w_idle & bus_if.v_i;
  assign w_abort   = ~w_idle & bus_if.abort_i;
  assign w_set     = ~w_idle & ~bus_if.abort_i & bus_if.set_i;
  assign w_en      = ~w_idle & ~bus_if.abort_i & ~bus_if.set_i & bus_if.en_i;
  assign w_uf      = w_en & w_zero;
  assign w_cnt_set = w_accept | w_abort | w_set | w_uf;

  always_comb begin
    w_cnt_val = '0;
    if (w_accept || w_set) begin
      w_cnt_val = w_clamped;
    end else if (w_uf && r_mode) begin
      w_cnt_val = r_reload;
    end
  end

  bsg_counter_down_set_en #(
    .width_p (width_lp)
  ) u_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .set_i   (w_cnt_set),
    .val_i   (w_cnt_val),
    .en_i    (w_en),
    .count_o (w_count),
    .zero_o  (w_zero)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= e_idle;
      r_reload    <= '0;
      r_mode      <= 1'(reload_default_p);
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_uf;
      case (r_state)
        e_idle: begin
          if (bus_if.v_i) begin
            r_reload <= w_clamped;
            r_mode   <= bus_if.periodic_i;
            r_state  <= e_run;
          end
        end
        e_run: begin
          if (bus_if.abort_i) begin
            r_state <= e_idle;
          end else if (bus_if.set_i) begin
            r_reload <= w_clamped;
            r_mode   <= bus_if.periodic_i;
          end else if (w_uf && !r_mode) begin
            r_state <= e_idle;
          end
        end
        default: r_state <= e_idle;
      endcase
    end
  end

`ifdef BSG_COUNTER_UNDERFLOW_EVENT_CNT_EN
  logic [event_cnt_width_gp-1:0] r_event_cnt;

  // Counts on the same edge that raises underflow_o, so the two stay aligned.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_event_cnt <= '0;
    end else if (w_accept || w_abort) begin
      r_event_cnt <= '0;
    end else if (w_uf && (r_event_cnt != '1)) begin
      r_event_cnt <= r_event_cnt + event_cnt_width_gp'(1);
    end
  end

  assign bus_if.underflow_cnt_o = r_event_cnt;
`endif

  assign bus_if.ready_o     = w_idle & ~reset_i;
  assign bus_if.busy_o      = ~w_idle;
  assign bus_if.count_o     = w_count;
  assign bus_if.underflow_o = r_underflow;

endmodule

// File: tb/tb_bsg_counter_underflow_reload_en.sv
// Directed and randomized bench for bsg_counter_underflow_reload_en with a behavioural model.
module tb_bsg_counter_underflow_reload_en;
  import bsg_counter_underflow_pkg::*;

  localparam int MAXV = 10;
  localparam int W    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsg_counter_underflow_reload_en_if #(.width_p(W)) bus();

  bsg_counter_underflow_reload_en #(
    .max_val_p        (MAXV),
    .reload_default_p (0)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_if  (bus)
  );

  int checks = 0;
  int errors = 0;

  int m_count, m_reload, m_evt;
  bit m_busy, m_mode, m_uf;
  int uf_tally;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_mode = 0; m_busy = 0; m_uf = 0; m_evt = 0;
  endtask

  function automatic int clampv(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Next state from the current model state and the inputs present before the edge.
  task automatic model_step();
    m_uf = 0;
    if (!m_busy) begin
      if (bus.v_i) begin
        m_count  = clampv(int'(bus.val_i));
        m_reload = m_count;
        m_mode   = bus.periodic_i;
        m_busy   = 1;
        m_evt    = 0;
      end
    end else if (bus.abort_i) begin
      m_count = 0; m_busy = 0; m_evt = 0;
    end else if (bus.set_i) begin
      m_count  = clampv(int'(bus.val_i));
      m_reload = m_count;
      m_mode   = bus.periodic_i;
    end else if (bus.en_i) begin
      if (m_count > 0) m_count = m_count - 1;
      else begin
        m_uf  = 1;
        m_evt = (m_evt < 255) ? m_evt + 1 : 255;
        if (m_mode) m_count = m_reload;
        else begin m_count = 0; m_busy = 0; end
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(bus.count_o), m_count);
    chk({tag, ".busy"}, 32'(bus.busy_o), 32'(m_busy));
    chk({tag, ".uf"}, 32'(bus.underflow_o), 32'(m_uf));
    chk({tag, ".ready"}, 32'(bus.ready_o), 32'(!m_busy));
`ifdef BSG_COUNTER_UNDERFLOW_EVENT_CNT_EN
    chk({tag, ".evt"}, 32'(bus.underflow_cnt_o), m_evt);
`endif
  endtask

  task automatic drive(input bit v, input int val, input bit per, input bit set, input bit en, input bit abort);
    bus.v_i        = v;
    bus.val_i      = W'(val);
    bus.periodic_i = per;
    bus.set_i      = set;
    bus.en_i       = en;
    bus.abort_i    = abort;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    if (m_uf) uf_tally++;
    chk_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst.count", 32'(bus.count_o), 0);
    chk("rst.busy", 32'(bus.busy_o), 0);
    chk("rst.uf", 32'(bus.underflow_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst.ready", 32'(bus.ready_o), 1);

    // Reset in the middle of a count
    drive(1, 5, 0, 0, 0, 0); step("mid.load");
    drive(0, 0, 0, 0, 1, 0); step("mid.en1"); step("mid.en2");
    chk("mid.count3", 32'(bus.count_o), 3);
    #2 rst = 1'b1;
    #1;
    chk("mid.async_count", 32'(bus.count_o), 0);
    chk("mid.async_busy", 32'(bus.busy_o), 0);
    chk("mid.async_uf", 32'(bus.underflow_o), 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("mid.ready", 32'(bus.ready_o), 1);

    // One-shot from 3
    drive(1, 3, 0, 0, 0, 0); step("os.load");
    chk("os.count_start", 32'(bus.count_o), 3);
    drive(0, 0, 0, 0, 1, 0);
    uf_tally = 0;
    for (int i = 0; i < 4; i++) step("os.run");
    chk("os.pulse", 32'(bus.underflow_o), 1);
    chk("os.idle", 32'(bus.busy_o), 0);
    drive(0, 0, 0, 0, 0, 0); step("os.after");
    chk("os.tally", uf_tally, 1);

    // Periodic reload of 2: load cycle plus 8 enabled cycles
    drive(1, 2, 1, 0, 0, 0); step("per.load");
    drive(0, 0, 0, 0, 1, 0);
    uf_tally = 0;
    for (int i = 0; i < 8; i++) step("per.run");
    chk("per.tally", uf_tally, 2);
    chk("per.busy", 32'(bus.busy_o), 1);
    drive(0, 0, 0, 0, 0, 1); step("per.abort");

    // Clamp and zero load
    drive(1, 15, 0, 0, 0, 0); step("clamp.load");
    chk("clamp.count", 32'(bus.count_o), MAXV);
    drive(0, 0, 0, 0, 0, 1); step("clamp.abort");
    drive(1, 0, 0, 0, 0, 0); step("zero.load");
    drive(0, 0, 0, 0, 1, 0); step("zero.en");
    chk("zero.pulse", 32'(bus.underflow_o), 1);

    // Priority: set over en, abort over en at zero
    drive(1, 4, 0, 0, 0, 0); step("pri.load");
    drive(0, 7, 0, 1, 1, 0); step("pri.set_en");
    chk("pri.count7", 32'(bus.count_o), 7);
    drive(0, 0, 0, 1, 0, 0); step("pri.set0");
    drive(0, 0, 0, 0, 1, 1); step("pri.abort_en");
    chk("pri.no_uf", 32'(bus.underflow_o), 0);
    chk("pri.idle", 32'(bus.busy_o), 0);

    // v_i held while busy must not be taken
    drive(1, 6, 0, 0, 0, 0); step("hold.load");
    drive(1, 2, 1, 0, 1, 0); step("hold.busy");
    chk("hold.count", 32'(bus.count_o), 5);

`ifdef BSG_COUNTER_UNDERFLOW_EVENT_CNT_EN
    drive(0, 0, 0, 0, 0, 1); step("evt.abort");
    drive(1, 0, 1, 0, 0, 0); step("evt.load");
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) step("evt.run");
    chk("evt.sat", 32'(bus.underflow_cnt_o), 255);
    drive(0, 0, 0, 1, 0, 0); step("evt.set_oneshot");
    chk("evt.set_keeps", 32'(bus.underflow_cnt_o), 255);
    drive(0, 0, 0, 0, 1, 0); step("evt.last");
    drive(1, 3, 0, 0, 0, 0); step("evt.reload");
    chk("evt.cleared", 32'(bus.underflow_cnt_o), 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(1, 0) == 1, $urandom_range(15, 0), $urandom_range(1, 0) == 1,
            $urandom_range(9, 0) == 0, $urandom_range(9, 0) < 7, $urandom_range(39, 0) == 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_counter_underflow_reload_en.md
Name: bsg_counter_underflow_reload_en

Overview:
- Loadable down-counter and timer. It is the counting-down counterpart to the team's up-counter-with-overflow.
- Accepts a start value over a valid/ready handshake.
- Decrements on en_i and emits a registered one-cycle underflow pulse when it is decremented at zero.
- On underflow it either reloads automatically from a shadow register (periodic mode) or returns to idle (one-shot mode).
- Used as a credit, timeout or period generator facing producers that use the up-counting overflow blocks.

Parameters:
- max_val_p, 2147483647: largest loadable count. Counter width width_lp = $clog2(max_val_p+1), which is 31 at the default.
- reload_default_p, 0: reset value of the mode bit. 0 = one-shot, 1 = periodic.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- reset_i  in  1  asynchronous reset, active-high.
- v_i  in  1  load request valid.
- val_i  in  width_lp  start and reload value; qualified by v_i or set_i.
- periodic_i  in  1  mode sampled on each accepted load (1 = auto-reload).
- ready_o  out  1  load accepted this cycle when v_i is also 1. High only in IDLE.
- set_i  in  1  force-load val_i in RUN (retarget without abort).
- en_i  in  1  decrement enable.
- abort_i  in  1  return to IDLE and clear the count.
- count_o  out  width_lp  current count.
- busy_o  out  1  state == RUN.
- underflow_o  out  1  registered one-cycle pulse per underflow event.

Behaviour:
- Reset (asynchronous, any time, including mid-count) sets:
  - state = IDLE
  - count_o = 0
  - reload register = 0
  - mode = reload_default_p
  - underflow_o = 0
  - busy_o = 0
  - ready_o = 1 once reset_i deasserts
- States are IDLE and RUN.
- Clamping: any loaded value above max_val_p is stored as max_val_p.
- IDLE:
  - ready_o = 1; en_i and set_i are ignored.
  - v_i & ready_o: count_o and reload register <= clamp(val_i); mode <= periodic_i; next state RUN.
  - Loading 0 is legal. The first en_i in RUN then underflows immediately.
- RUN priority, highest first:
  1. abort_i: count_o <= 0, state <= IDLE, no underflow pulse.
  2. set_i: count_o and reload register <= clamp(val_i); mode <= periodic_i; stay in RUN. A simultaneous en_i is ignored that cycle.
  3. en_i & count_o != 0: count_o <= count_o - 1.
  4. en_i & count_o == 0 is an underflow event:
     - underflow_o = 1 in the next cycle for exactly one cycle.
     - If mode = 1: count_o <= reload register, stay in RUN.
     - If mode = 0: count_o <= 0, state <= IDLE.
  5. Otherwise count_o holds.
- v_i in RUN is not accepted (ready_o = 0). The producer must hold v_i.
- Back-to-back underflows: with reload 0 in periodic mode and en_i held high, underflow_o is high every cycle.
- Latency:
  - Load to first decrement: 1 cycle (accept at edge N, decrement possible at edge N+1).
  - count_o is updated on the edge that follows each qualifying en_i.
- Arithmetic is unsigned. count_o never goes below 0 and never exceeds max_val_p.

Optional Feature:
- Macro BSG_COUNTER_UNDERFLOW_EVENT_CNT_EN.
- Defined:
  - Adds output port underflow_cnt_o [7:0]: a saturating count of underflow events.
  - Increments with each underflow_o pulse and sticks at 255.
  - Cleared to 0 by reset, by an accepted load in IDLE, and by abort_i. set_i does not clear it.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bsg_counter_underflow_pkg holds:
  - the state typedef (e_idle, e_run)
  - localparam event_cnt_width_gp = 8
- One sub-module is natural: bsg_counter_down_set_en. It is the width_lp down-counter datapath with set/en and a zero detect. The FSM, reload register, mode bit, clamp and underflow register live in the top module.

Test Plan:
- Reset mid-count: load 5, apply 2 en_i, assert reset_i between edges -> count_o = 0, busy_o = 0, underflow_o = 0 immediately (asynchronous), ready_o = 1 after release.
- One-shot: load 3 with periodic_i = 0, hold en_i -> count_o 3, 2, 1, 0; underflow_o pulses once the cycle after the en_i at 0; state IDLE with count_o = 0.
- Periodic: load 2 with periodic_i = 1, hold en_i for 9 cycles -> count_o sequence 2, 1, 0, 2, 1, 0, ...; underflow_o high on cycles 4 and 7 only; busy_o stays 1.
- Clamp and zero load, with max_val_p = 10:
  - load 15 -> count_o = 10.
  - load 0, then a single en_i -> underflow_o pulse the next cycle.
- Priority: in RUN at count 4, assert set_i = 1 (val_i = 7) together with en_i -> count_o = 7. Next cycle assert abort_i together with en_i at count 0 -> IDLE, no underflow pulse.
- Macro build: periodic reload 0, en_i held for 300 cycles -> underflow_cnt_o saturates at 255; an accepted new load clears it to 0.
